// File: rtl/approx_add_pipe.sv
// approx_add_pipe: pipelined lower-part-OR approximate adder with optional error monitor
// Build option: define APPROX_ERR_MON_EN to include the exact-sum monitor and its counters.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_a, in_b are W-bit operands
//   out_valid/out_ready   result handshake; out_sum is the (W+1)-bit approximate sum
//   mon_clr               synchronous clear of the monitor counters
//   mon_samples, mon_errs delivered results / delivered results that differ from exact
//   mon_max_err           largest |approx - exact| seen
//   mon_abs_acc           saturating sum of |approx - exact|
module approx_add_pipe #(
    parameter int W  = 8,
    parameter int K  = 2,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W:0]    out_sum,
    input  logic          mon_clr,
    output logic [CW-1:0] mon_samples,
    output logic [CW-1:0] mon_errs,
    output logic [W:0]    mon_max_err,
    output logic [CW-1:0] mon_abs_acc
);
    localparam int H  = W / 2;
    localparam int HW = W - H;
    // OR-approximated bit counts that fall into the low and high halves
    localparam int K1 = (K < H) ? K : H;
    localparam int K2 = (K > H) ? K - H : 0;
    localparam logic [W-1:0]  CK_MASK = (K == 0) ? '0 : (W'(1) << ((K == 0) ? 0 : K - 1));
    localparam logic [H-1:0]  M1 = ~({H{1'b1}} << K1);
    localparam logic [HW-1:0] M2 = ~({HW{1'b1}} << K2);

    logic          v1_q, v1_d, v2_q, v2_d, adv1, adv2, ck;
    logic [H-1:0]  lo_q, lo_d;
    logic          c_q, c_d;
    logic [HW-1:0] ah_q, ah_d, bh_q, bh_d;
    logic [W:0]    sum_q, sum_d;
    logic [H:0]    lo_ext;
    logic [HW:0]   hi_ext;

    // When K >= H the low half is pure OR and lo_ext[H] carries the LOA carry forward.
    always_comb begin
        adv2   = !v2_q || out_ready;
        adv1   = !v1_q || adv2;
        ck     = |(in_a & in_b & CK_MASK);
        lo_ext = ((((H+1)'(in_a[H-1:0] >> K1)) + ((H+1)'(in_b[H-1:0] >> K1)) + (H+1)'(ck)) << K1)
               | {1'b0, (in_a[H-1:0] | in_b[H-1:0]) & M1};
        hi_ext = ((((HW+1)'(ah_q >> K2)) + ((HW+1)'(bh_q >> K2)) + (HW+1)'(c_q)) << K2)
               | {1'b0, (ah_q | bh_q) & M2};
        v1_d   = adv1 ? in_valid : v1_q;
        lo_d   = (adv1 && in_valid) ? lo_ext[H-1:0] : lo_q;
        c_d    = (adv1 && in_valid) ? lo_ext[H] : c_q;
        ah_d   = (adv1 && in_valid) ? in_a[W-1:H] : ah_q;
        bh_d   = (adv1 && in_valid) ? in_b[W-1:H] : bh_q;
        v2_d   = adv2 ? v1_q : v2_q;
        sum_d  = (adv2 && v1_q) ? {hi_ext, lo_q} : sum_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            lo_q  <= '0;
            c_q   <= 1'b0;
            ah_q  <= '0;
            bh_q  <= '0;
            sum_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            lo_q  <= lo_d;
            c_q   <= c_d;
            ah_q  <= ah_d;
            bh_q  <= bh_d;
            sum_q <= sum_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = v2_q;
    assign out_sum   = sum_q;

`ifdef APPROX_ERR_MON_EN
    localparam int AW = ((CW > W + 1) ? CW : W + 1) + 1;

    logic [W:0]    ex1_q, ex1_d, ex2_q, ex2_d, diff, mx_q, mx_d;
    logic [CW-1:0] s_q, s_d, e_q, e_d, acc_q, acc_d;
    logic [AW-1:0] acc_sum;

    always_comb begin
        ex1_d   = (adv1 && in_valid) ? (W+1)'(in_a) + (W+1)'(in_b) : ex1_q;
        ex2_d   = (adv2 && v1_q) ? ex1_q : ex2_q;
        diff    = (sum_q >= ex2_q) ? sum_q - ex2_q : ex2_q - sum_q;
        acc_sum = AW'(acc_q) + AW'(diff);
        s_d     = s_q;
        e_d     = e_q;
        mx_d    = mx_q;
        acc_d   = acc_q;
        if (mon_clr) begin
            s_d   = '0;
            e_d   = '0;
            mx_d  = '0;
            acc_d = '0;
        end else if (v2_q && out_ready) begin
            s_d  = (&s_q) ? s_q : s_q + 1'b1;
            mx_d = (diff > mx_q) ? diff : mx_q;
            if (diff != '0) begin
                e_d   = (&e_q) ? e_q : e_q + 1'b1;
                acc_d = (acc_sum > AW'({CW{1'b1}})) ? '1 : acc_sum[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex1_q <= '0;
            ex2_q <= '0;
            s_q   <= '0;
            e_q   <= '0;
            mx_q  <= '0;
            acc_q <= '0;
        end else begin
            ex1_q <= ex1_d;
            ex2_q <= ex2_d;
            s_q   <= s_d;
            e_q   <= e_d;
            mx_q  <= mx_d;
            acc_q <= acc_d;
        end
    end

    assign mon_samples = s_q;
    assign mon_errs    = e_q;
    assign mon_max_err = mx_q;
    assign mon_abs_acc = acc_q;
`else
    logic unused_mon_clr;
    assign unused_mon_clr = mon_clr;
    assign mon_samples    = '0;
    assign mon_errs       = '0;
    assign mon_max_err    = '0;
    assign mon_abs_acc    = '0;
`endif
endmodule

// File: tb/tb_approx_add_pipe.sv
// tb_approx_add_pipe: scoreboard bench for approx_add_pipe (K=2 instance plus an exact K=0 instance)
module tb_approx_add_pipe;
`ifdef APPROX_ERR_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    typedef struct packed {
        logic [8:0] ap;
        logic [8:0] ex;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        mon_clr = 1'b0;
    logic [7:0]  in_a = '0, in_b = '0;
    logic        in_ready, out_valid, in_ready0, out_valid0;
    logic [8:0]  out_sum, out_sum0, mon_max_err, mon_max_err0;
    logic [15:0] mon_samples, mon_errs, mon_abs_acc, mon_samples0, mon_errs0, mon_abs_acc0;

    exp_t q[$];
    int   checks = 0, errors = 0;
    int   m_s = 0, m_e = 0, m_mx = 0, m_acc = 0;
    logic stalled = 1'b0;
    logic [8:0] held = '0;
    logic done;
    int   idx;

    approx_add_pipe #(.W(8), .K(2), .CW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .mon_clr(mon_clr), .mon_samples(mon_samples),
        .mon_errs(mon_errs), .mon_max_err(mon_max_err), .mon_abs_acc(mon_abs_acc)
    );

    approx_add_pipe #(.W(8), .K(0), .CW(16)) u_k0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready),
        .out_sum(out_sum0), .mon_clr(mon_clr), .mon_samples(mon_samples0),
        .mon_errs(mon_errs0), .mon_max_err(mon_max_err0), .mon_abs_acc(mon_abs_acc0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] model_sum(input logic [7:0] a, input logic [7:0] b, input int k);
        logic [8:0] s;
        logic c;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < k; i++) s[i] = a[i] | b[i];
        if (k > 0) c = a[k-1] & b[k-1];
        for (int i = k; i < 8; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        s[8] = c;
        return s;
    endfunction

    // Inputs change 1 time unit after posedge, so the negedge sees what the next posedge will sample.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_s = 0; m_e = 0; m_mx = 0; m_acc = 0;
            stalled = 1'b0;
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_in_ready", 32'(in_ready), 1);
            check("rst_out_sum", 32'(out_sum), 0);
            check("rst_mon_samples", 32'(mon_samples), 0);
            check("rst_mon_acc", 32'(mon_abs_acc), 0);
        end else begin
            check("mon_samples", 32'(mon_samples), MON ? m_s : 0);
            check("mon_errs", 32'(mon_errs), MON ? m_e : 0);
            check("mon_max_err", 32'(mon_max_err), MON ? m_mx : 0);
            check("mon_abs_acc", 32'(mon_abs_acc), MON ? m_acc : 0);
            check("k0_mon_errs", 32'(mon_errs0), 0);
            check("k0_mon_samples", 32'(mon_samples0), MON ? m_s : 0);
            check("k0_out_valid", 32'(out_valid0), 32'(out_valid));
            if (stalled) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_sum", 32'(out_sum), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("spurious_out", 32'(out_valid), 0);
                else begin
                    exp_t e;
                    int d;
                    e = q.pop_front();
                    check("sum_k2", 32'(out_sum), 32'(e.ap));
                    check("sum_k0", 32'(out_sum0), 32'(e.ex));
                    d = (e.ap > e.ex) ? int'(e.ap) - int'(e.ex) : int'(e.ex) - int'(e.ap);
                    if (!mon_clr) begin
                        m_s = (m_s < 65535) ? m_s + 1 : m_s;
                        if (d != 0) begin
                            m_e = (m_e < 65535) ? m_e + 1 : m_e;
                            m_acc = (m_acc + d > 65535) ? 65535 : m_acc + d;
                        end
                        if (d > m_mx) m_mx = d;
                    end
                end
            end
            if (mon_clr) begin
                m_s = 0; m_e = 0; m_mx = 0; m_acc = 0;
            end
            stalled = out_valid && !out_ready;
            held = out_sum;
            if (in_valid && in_ready)
                q.push_back('{ap: model_sum(in_a, in_b, 2), ex: 9'(in_a) + 9'(in_b)});
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 100) check("drain_timeout", 32'(q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        // Two-cycle latency on 0x03 + 0x01
        in_valid = 1'b1; in_a = 8'h03; in_b = 8'h01;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("lat_cycle1", 32'(out_valid), 0);
        @(posedge clk);
        #1 check("lat_cycle2", 32'(out_valid), 1);
        check("sum_03_01", 32'(out_sum), 32'h003);
        drain();
        check("dir_errs1", 32'(mon_errs), MON ? 1 : 0);
        check("dir_max1", 32'(mon_max_err), MON ? 1 : 0);
        send(8'h02, 8'h02);
        send(8'hFF, 8'h01);
        drain();
        check("dir_errs3", 32'(mon_errs), MON ? 3 : 0);
        check("dir_max2", 32'(mon_max_err), MON ? 2 : 0);
        check("dir_acc4", 32'(mon_abs_acc), MON ? 4 : 0);
        // Clear, then 1000 random pairs back-to-back
        mon_clr = 1'b1;
        @(posedge clk);
        #1 mon_clr = 1'b0;
        for (int i = 0; i < 1000; i++) send(8'($urandom), 8'($urandom));
        drain();
        check("rand_samples", 32'(mon_samples), MON ? 1000 : 0);
        check("rand_k0_samples", 32'(mon_samples0), MON ? 1000 : 0);
        // Random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) send(8'($urandom), 8'($urandom));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        // Five pairs with out_ready low for cycles 3..8
        idx = 0;
        for (int cyc = 0; cyc < 40 && (idx < 5 || q.size() != 0 || out_valid); cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 8);
            in_valid = idx < 5;
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            @(negedge clk);
            if (cyc == 5) check("stall_in_ready", 32'(in_ready), 0);
            if (cyc == 9) check("rise_in_ready", 32'(in_ready), 1);
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stall_sent", 32'(idx), 5);
        check("stall_queue", 32'(q.size()), 0);
        // Clear coinciding with an output transfer
        out_ready = 1'b0;
        send(8'h03, 8'h01);
        @(posedge clk);
        #1 mon_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 mon_clr = 1'b0;
        check("clr_samples", 32'(mon_samples), 0);
        check("clr_errs", 32'(mon_errs), 0);
        check("clr_max", 32'(mon_max_err), 0);
        check("clr_acc", 32'(mon_abs_acc), 0);
        // Reset mid-stream
        send(8'h03, 8'h01);
        send(8'h02, 8'h02);
        send(8'h7F, 8'h05);
        rst_n = 1'b0;
        #1 check("rstmid_out_valid", 32'(out_valid), 0);
        check("rstmid_in_ready", 32'(in_ready), 1);
        check("rstmid_samples", 32'(mon_samples), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'hAA, 8'h55);
        drain();
        check("post_rst_samples", 32'(mon_samples), MON ? 1 : 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
